// File: rtl/rv_isa_pkg.sv
// RV64I encoding helpers and immediate classes shared by the
// constant materialiser datapath.
package rv_isa_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;

    localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IMM_SHORT,
        IMM_MID,
        IMM_LONG
    } imm_class_e;

    function automatic logic [ILEN-1:0] enc_i(
        input logic [6:0]  op,
        input logic [2:0]  f3,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [11:0] imm12
    );
        return {imm12, rs1, f3, rd, op};
    endfunction

    function automatic logic [ILEN-1:0] enc_u(
        input logic [6:0]  op,
        input logic [4:0]  rd,
        input logic [19:0] imm20
    );
        return {imm20, rd, op};
    endfunction

    function automatic logic [ILEN-1:0] enc_slli(
        input logic [4:0] rd,
        input logic [5:0] sh
    );
        return {6'b000000, sh, rd, F3_SLL, rd, OP_IMM};
    endfunction

endpackage

// File: rtl/imm_chunk_split.sv
// Splits a 64-bit constant into a LUI/ADDI(W) base plus three
// 12-bit ADDI chunks that follow successive 12-bit left shifts.
module imm_chunk_split
    import rv_isa_pkg::*;
(
    input  logic [XLEN-1:0] v,
    output imm_class_e      cls,
    output logic            base_short,
    output logic [19:0]     hi,
    output logic [11:0]     lo,
    output logic            lo_nz,
    output logic [11:0]     c2,
    output logic [11:0]     c1,
    output logic [11:0]     c0,
    output logic [2:0]      c_nz
);

    logic [52:0] v1;
    logic [41:0] v2;
    logic [30:0] v3;
    logic [31:0] b;
    logic        fit12;
    logic        fit32;

    // (x - sext(x[11:0])) >>> 12 equals floor(x/4096) plus the borrow bit x[11]
    assign v1 = {v[63], v[63:12]} + {52'd0, v[11]};
    assign v2 = {v1[52], v1[52:12]} + {41'd0, v1[11]};
    assign v3 = {v2[41], v2[41:12]} + {30'd0, v2[11]};

    assign fit12 = (v[63:11] == {53{v[11]}});
    assign fit32 = (v[63:31] == {33{v[31]}});

    always_comb begin
        cls = IMM_LONG;
        if (fit12) begin
            cls = IMM_SHORT;
        end else if (fit32) begin
            cls = IMM_MID;
        end
    end

    assign b = (cls == IMM_LONG) ? {v3[30], v3} : v[31:0];

    assign base_short = (b[31:11] == {21{b[11]}});
    assign hi         = b[31:12] + {19'd0, b[11]};
    assign lo         = b[11:0];
    assign lo_nz      = |b[11:0];

    assign c0   = v[11:0];
    assign c1   = v1[11:0];
    assign c2   = v2[11:0];
    assign c_nz = {|v2[11:0], |v1[11:0], |v[11:0]};

endmodule

// File: rtl/imm_materializer.sv
// Expands "li rd, value" into an RV64I instruction stream,
// one instruction per valid/ready handshake.
module imm_materializer
    import rv_isa_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [4:0]      req_rd,
    input  logic [XLEN-1:0] req_value,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [ILEN-1:0] instr,
    output logic            instr_last,
    output logic            busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BASE_HI,
        S_BASE_LO,
        S_SHIFT,
        S_ADD
    } state_e;

    state_e     state, state_d;
    logic [1:0] idx, idx_d;

    imm_class_e sp_cls;
    logic       sp_short;
    logic [19:0] sp_hi;
    logic [11:0] sp_lo;
    logic       sp_lo_nz;
    logic [11:0] sp_c2, sp_c1, sp_c0;
    logic [2:0] sp_c_nz;

    logic [4:0]  rd_q;
    logic        nop_q;
    logic        long_q;
    logic        short_q;
    logic [19:0] hi_q;
    logic [11:0] lo_q;
    logic        lo_nz_q;
    logic [11:0] c2_q, c1_q, c0_q;
    logic [2:0]  c_nz_q;

    logic        accept;
    logic        fire;
    logic [11:0] c_sel;
    logic        c_sel_nz;

    imm_chunk_split u_split (
        .v          (req_value),
        .cls        (sp_cls),
        .base_short (sp_short),
        .hi         (sp_hi),
        .lo         (sp_lo),
        .lo_nz      (sp_lo_nz),
        .c2         (sp_c2),
        .c1         (sp_c1),
        .c0         (sp_c0),
        .c_nz       (sp_c_nz)
    );

    assign req_ready   = (state == S_IDLE);
    assign busy        = (state != S_IDLE);
    assign instr_valid = (state != S_IDLE);
    assign accept      = req_valid && req_ready;
    assign fire        = instr_valid && instr_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            idx   <= 2'd2;
        end else begin
            state <= state_d;
            idx   <= idx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            rd_q    <= req_rd;
            nop_q   <= (req_rd == 5'd0);
            long_q  <= (sp_cls == IMM_LONG);
            short_q <= sp_short;
            hi_q    <= sp_hi;
            lo_q    <= sp_lo;
            lo_nz_q <= sp_lo_nz;
            c2_q    <= sp_c2;
            c1_q    <= sp_c1;
            c0_q    <= sp_c0;
            c_nz_q  <= sp_c_nz;
        end
    end

    always_comb begin
        c_sel    = c0_q;
        c_sel_nz = c_nz_q[0];
        unique case (idx)
            2'd2: begin
                c_sel    = c2_q;
                c_sel_nz = c_nz_q[2];
            end
            2'd1: begin
                c_sel    = c1_q;
                c_sel_nz = c_nz_q[1];
            end
            default: begin
                c_sel    = c0_q;
                c_sel_nz = c_nz_q[0];
            end
        endcase
    end

    always_comb begin
        state_d    = state;
        idx_d      = idx;
        instr      = '0;
        instr_last = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (req_valid) begin
                    state_d = S_BASE_HI;
                    idx_d   = 2'd2;
                end
            end
            S_BASE_HI: begin
                if (nop_q) begin
                    instr      = NOP;
                    instr_last = 1'b1;
                end else if (short_q) begin
                    instr      = enc_i(OP_IMM, F3_ADD, rd_q, 5'd0, lo_q);
                    instr_last = !long_q;
                end else begin
                    instr      = enc_u(OP_LUI, rd_q, hi_q);
                    instr_last = !long_q && !lo_nz_q;
                end
                if (fire) begin
                    if (instr_last) begin
                        state_d = S_IDLE;
                    end else if (!short_q && lo_nz_q) begin
                        state_d = S_BASE_LO;
                    end else begin
                        state_d = S_SHIFT;
                    end
                end
            end
            S_BASE_LO: begin
                instr      = enc_i(OP_IMM32, F3_ADD, rd_q, rd_q, lo_q);
                instr_last = !long_q;
                if (fire) begin
                    state_d = instr_last ? S_IDLE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                instr      = enc_slli(rd_q, 6'd12);
                instr_last = (idx == 2'd0) && !c_sel_nz;
                if (fire) begin
                    if (instr_last) begin
                        state_d = S_IDLE;
                    end else if (c_sel_nz) begin
                        state_d = S_ADD;
                    end else begin
                        idx_d = idx - 2'd1;
                    end
                end
            end
            S_ADD: begin
                instr      = enc_i(OP_IMM, F3_ADD, rd_q, rd_q, c_sel);
                instr_last = (idx == 2'd0);
                if (fire) begin
                    if (instr_last) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_SHIFT;
                        idx_d   = idx - 2'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
